tick_period_meter: RTL and testbench
====================================

# tick_period_meter

Measures the period, in `clock` cycles, between consecutive rising edges of a pulse train and classifies it against the three slow rates our rate dividers produce. It is the receive-side checker for the divider enables. It sits beside the divider/mux path, or on an external pin, and drives HEX/LEDR status. It also serves as an on-board self-test of the selected rate.

## Interface

Parameters:

- `CNT_WIDTH`, 28: width of the cycle counter and of `period`. The maximum measurable period is 2^CNT_WIDTH−1.
- `P1`, 50000000: nominal period for rate code 2'b01.
- `P2`, 100000000: nominal period for rate code 2'b10.
- `P3`, 200000000: nominal period for rate code 2'b11.
- `TOL`, 2: allowed ± deviation, in cycles, for a rate match.

Ports:

- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `pulse_in`  in  1  monitored signal; may be asynchronous to `clock`.
- `period`  out  CNT_WIDTH  last captured period in cycles.
- `valid`  out  1  one-cycle strobe when `period` updates.
- `rate_code`  out  2  classification of `period`: 00 = no match, 01/10/11 = P1/P2/P3.
- `overflow`  out  1  sticky; the counter saturated without seeing an edge.
- `busy`  out  1  high while in MEASURE.

## Operation

- **Input path:** `pulse_in` passes through a 2-flop synchronizer and then an edge register. `edge` = sync_q & ~prev_q. Only rising edges count; level or width is ignored.
- **State machine:** two states, IDLE and MEASURE.
  - IDLE, on `edge`: go to MEASURE with count <= 1. `valid` is not asserted; the first edge only arms the meter.
  - MEASURE, each cycle without `edge`: count <= count+1.
  - MEASURE, on `edge`: `period` <= count, `valid` = 1 for that cycle, count <= 1, stay in MEASURE, `overflow` <= 0.
  - MEASURE, count == 2^CNT_WIDTH−1 and no `edge`: `overflow` <= 1, go to IDLE, `period` unchanged, `valid` stays 0.
- **Period definition:** with edges detected at cycles t and t+N, `period` = N. The counter never wraps; it saturates as described above.
- **Edge at saturation:** if `edge` and count == max occur together, the edge wins. `period` = 2^CNT_WIDTH−1 with `valid`, and `overflow` is not set.
- **Classification:** `rate_code` is registered together with `period` and updates on the same cycle.
  - 01 if |period−P1| ≤ TOL.
  - 10 if |period−P2| ≤ TOL.
  - 11 if |period−P3| ≤ TOL.
  - 00 otherwise.
  - Checks are made in order P1, P2, P3 and the first match wins. Comparisons are unsigned, with no underflow when P−TOL < 0 (the lower bound clamps to 0).
- **Busy:** `busy` = (state == MEASURE).

## Timing

- **Reset values:** `clear` high forces state IDLE, count 0, `period` 0, `valid` 0, `rate_code` 00, `overflow` 0, `busy` 0, and sync/edge flops 0. This takes effect immediately and asynchronously. Deasserting `clear` mid-measurement discards the partial count.
- **Edge detection latency:** a `pulse_in` rising edge that meets setup before clock edge k is detected as `edge` at cycle k+2. `valid` and the new `period`/`rate_code` are visible after the clock edge of cycle k+2. The latency is constant, so it cancels out of the period.
- **Minimum measurable period:** 2 cycles. This requires `pulse_in` low for at least one cycle and high for at least one cycle, both sampled by the synchronizer.
- **Output stability:** `valid` is exactly one cycle wide per captured period, never back-to-back except when the period is 1 (not reachable, since the minimum is 2). `period` and `rate_code` hold until the next capture or `clear`.
- **Overflow flag:** `overflow` sets on the cycle the state returns to IDLE. It clears only on a later capture or on `clear`.

## Test plan

All scenarios use CNT_WIDTH=8, P1=5, P2=10, P3=20, TOL=0.

- **Reset state:** assert `clear` mid-run with count at 37 -> all outputs 0 that cycle, `busy` 0. After release, the first edge gives no `valid`.
- **Periodic train:** 1-cycle `pulse_in` every 10 cycles -> after the arming edge, `valid` every 10 cycles with `period`=10, `rate_code`=10, `overflow`=0.
- **Rate switching:** periods 5, 20, 7 -> `rate_code` sequence 01, 11, 00. Each update coincides with its `valid`. A wide-high pulse with period 20 also gives 20.
- **Saturation:** arm, then no edge for 300 cycles -> `overflow`=1 and `busy`=0 after count hits 255, `period` unchanged. The next two edges 12 apart give `period`=12, `valid`, and `overflow` back to 0.
- **Simultaneous edge and saturation:** edge lands exactly when count=255 -> `valid`, `period`=255, `rate_code`=00, `overflow` stays 0, `busy` stays 1.
- **Asynchronous input:** `pulse_in` edges with a random sub-cycle offset and a nominal 20-cycle period -> every `period` is in {19, 20, 21}. Minimum-period input (period 2, alternating each cycle) -> `period`=2 continuously.

Source files
------------

// File: rtl/tick_period_meter.sv
// Measures clock cycles between rising edges of pulse_in and classifies the
// period against three nominal divider rates.
module tick_period_meter #(
   parameter int unsigned CNT_WIDTH = 28,
   parameter int unsigned P1        = 50000000,
   parameter int unsigned P2        = 100000000,
   parameter int unsigned P3        = 200000000,
   parameter int unsigned TOL       = 2
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 pulse_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic                 valid,
   output logic [1:0]           rate_code,
   output logic                 overflow,
   output logic                 busy
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StMeasure = 1'b1;

   // One spare bit above the wider of count/nominal so P+TOL never wraps.
   localparam int unsigned CmpWidth = ((CNT_WIDTH > 32) ? CNT_WIDTH : 32) + 1;
   localparam logic [CNT_WIDTH-1:0] CountMax = '1;
   localparam logic [CNT_WIDTH-1:0] CountOne = CNT_WIDTH'(1);

   logic                 sync1_q, sync2_q, prev_q;
   logic                 edge_det;
   logic [0:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;
   logic [1:0]           rate_q, rate_d;
   logic                 valid_q, valid_d;
   logic                 overflow_q, overflow_d;

   function automatic logic in_window(input logic [CNT_WIDTH-1:0] value,
                                      input int unsigned nominal);
      logic [CmpWidth-1:0] v, lo, hi;
      v  = CmpWidth'(value);
      hi = CmpWidth'(nominal) + CmpWidth'(TOL);
      lo = (nominal >= TOL) ? CmpWidth'(nominal - TOL) : '0;
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic logic [1:0] classify(input logic [CNT_WIDTH-1:0] value);
      if (in_window(value, P1)) begin
         return 2'b01;
      end else if (in_window(value, P2)) begin
         return 2'b10;
      end else if (in_window(value, P3)) begin
         return 2'b11;
      end
      return 2'b00;
   endfunction

   assign edge_det = sync2_q & ~prev_q;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= pulse_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      period_d   = period_q;
      rate_d     = rate_q;
      valid_d    = 1'b0;
      overflow_d = overflow_q;
      case (state_q)
         StIdle: begin
            // The first edge only arms the meter; no period is known yet.
            if (edge_det) begin
               state_d = StMeasure;
               count_d = CountOne;
            end
         end
         default: begin
            // An edge takes priority over saturation at the same count.
            if (edge_det) begin
               period_d   = count_q;
               rate_d     = classify(count_q);
               valid_d    = 1'b1;
               count_d    = CountOne;
               overflow_d = 1'b0;
            end else if (count_q == CountMax) begin
               overflow_d = 1'b1;
               state_d    = StIdle;
               count_d    = '0;
            end else begin
               count_d = count_q + CountOne;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q    <= StIdle;
         count_q    <= '0;
         period_q   <= '0;
         rate_q     <= 2'b00;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         period_q   <= period_d;
         rate_q     <= rate_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign period    = period_q;
   assign valid     = valid_q;
   assign rate_code = rate_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q == StMeasure);

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: table-driven edge trains scored against a queue
// of expected captures, plus reset, saturation and asynchronous-input sequences.
module tb_tick_period_meter;

   typedef struct {
      int unsigned gap;
      int unsigned high;
      logic [7:0]  exp_period;
      logic [1:0]  exp_rate;
   } vec_t;

   typedef struct {
      logic [7:0]  period;
      logic [1:0]  rate;
      int unsigned slack;
      bit          chk_rate;
   } exp_t;

   logic       clock;
   logic       clear;
   logic       pulse_in;
   logic [7:0] period;
   logic       valid;
   logic [1:0] rate_code;
   logic       overflow;
   logic       busy;

   int   passed = 0;
   int   total  = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[$];

   tick_period_meter #(
      .CNT_WIDTH (8),
      .P1        (5),
      .P2        (10),
      .P3        (20),
      .TOL       (0)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .pulse_in  (pulse_in),
      .period    (period),
      .valid     (valid),
      .rate_code (rate_code),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Scoreboard side: every valid strobe must match the oldest pending capture.
   always @(negedge clock) begin
      if (valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 1'b0, 1, 0);
         end else begin
            int diff;
            mon_e = sb_q.pop_front();
            diff  = int'(period) - int'(mon_e.period);
            if (diff < 0) diff = -diff;
            check("period", diff <= int'(mon_e.slack), period, mon_e.period);
            if (mon_e.chk_rate) check("rate_code", rate_code == mon_e.rate, rate_code, mon_e.rate);
            check("overflow_at_valid", overflow == 1'b0, overflow, 0);
            check("busy_at_valid", busy == 1'b1, busy, 1);
         end
      end
   end

   // Entered at the negedge where pulse_in has just risen; ends on the next rise.
   task automatic drive_period(input int unsigned n, input int unsigned h, input logic [7:0] p,
                               input logic [1:0] r, input int unsigned slack, input bit cr);
      repeat (h) @(negedge clock);
      pulse_in = 1'b0;
      repeat (n - h) @(negedge clock);
      sb_q.push_back('{p, r, slack, cr});
      pulse_in = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 10; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clock);
         #1;
      end
      check(name, sb_q.size() == 0, sb_q.size(), 0);
      @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned off;

      vecs.push_back('{10, 1, 8'd10, 2'b10});
      vecs.push_back('{10, 1, 8'd10, 2'b10});
      vecs.push_back('{10, 1, 8'd10, 2'b10});
      vecs.push_back('{5, 1, 8'd5, 2'b01});
      vecs.push_back('{20, 1, 8'd20, 2'b11});
      vecs.push_back('{7, 1, 8'd7, 2'b00});
      vecs.push_back('{20, 15, 8'd20, 2'b11});
      vecs.push_back('{2, 1, 8'd2, 2'b00});
      vecs.push_back('{2, 1, 8'd2, 2'b00});
      vecs.push_back('{2, 1, 8'd2, 2'b00});
      vecs.push_back('{2, 1, 8'd2, 2'b00});
      vecs.push_back('{3, 2, 8'd3, 2'b00});

      clear    = 1'b1;
      pulse_in = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_period", period == 8'd0, period, 0);
      check("reset_valid", valid == 1'b0, valid, 0);
      check("reset_rate", rate_code == 2'b00, rate_code, 0);
      check("reset_overflow", overflow == 1'b0, overflow, 0);
      check("reset_busy", busy == 1'b0, busy, 0);
      clear = 1'b0;

      // Arm, let the count run to about 37, then clear asynchronously.
      @(negedge clock);
      pulse_in = 1'b1;
      @(negedge clock);
      pulse_in = 1'b0;
      repeat (38) @(negedge clock);
      check("busy_armed", busy == 1'b1, busy, 1);
      #2 clear = 1'b1;
      #1;
      check("clear_period", period == 8'd0, period, 0);
      check("clear_valid", valid == 1'b0, valid, 0);
      check("clear_rate", rate_code == 2'b00, rate_code, 0);
      check("clear_overflow", overflow == 1'b0, overflow, 0);
      check("clear_busy", busy == 1'b0, busy, 0);
      @(negedge clock);
      clear = 1'b0;

      // Re-arm: this edge must not strobe valid.
      @(negedge clock);
      pulse_in = 1'b1;
      foreach (vecs[i]) begin
         drive_period(vecs[i].gap, vecs[i].high, vecs[i].exp_period, vecs[i].exp_rate, 0, 1'b1);
      end
      @(negedge clock);
      pulse_in = 1'b0;
      drain("drain_table");

      // Saturation: no edge for 300 cycles.
      repeat (300) @(negedge clock);
      check("sat_overflow", overflow == 1'b1, overflow, 1);
      check("sat_busy", busy == 1'b0, busy, 0);
      check("sat_period_held", period == 8'd3, period, 3);
      check("sat_valid", valid == 1'b0, valid, 0);

      // Re-arm, capture 12, then an edge landing exactly at count 255.
      pulse_in = 1'b1;
      drive_period(12, 1, 8'd12, 2'b00, 0, 1'b1);
      drive_period(255, 1, 8'd255, 2'b00, 0, 1'b1);
      @(negedge clock);
      pulse_in = 1'b0;
      drain("drain_sat");
      check("edge_at_max_busy", busy == 1'b1, busy, 1);
      check("edge_at_max_overflow", overflow == 1'b0, overflow, 0);
      check("edge_at_max_period", period == 8'd255, period, 255);

      repeat (300) @(negedge clock);
      check("overflow_again", overflow == 1'b1, overflow, 1);

      // Asynchronous edges: random sub-cycle offset, nominal period 20.
      for (int k = 0; k < 12; k++) begin
         off = $urandom_range(1, 8);
         if (off >= 5) off++;
         #(off);
         if (k > 0) sb_q.push_back('{8'd20, 2'b00, 1, 1'b0});
         pulse_in = 1'b1;
         repeat (5) @(negedge clock);
         pulse_in = 1'b0;
         repeat (15) @(negedge clock);
      end
      drain("drain_async");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
